// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_mult_if
// Brief    : Start/busy/done handshake and operand/product bundle for the
//            sequential Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_seq_mult_if #(
    parameter int W = 8
);
    logic             start;
    logic             is_signed;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_mult
// Brief    : Radix-2 Booth multiplier, one Booth step per clock, signed or
//            unsigned per operation, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_mult #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_seq_mult_if.slave bus
);
    localparam int            CW     = $clog2(W + 1);
    localparam logic [CW-1:0] C_LAST = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W:0]        r_m;
    logic [W:0]        r_q;
    logic              r_e;
    logic [W+1:0]      r_a;
    logic [CW-1:0]     r_cnt;
    logic [2*W-1:0]    r_product;

    logic              w_accept;
    logic              w_last;
    logic              w_busy;
    logic              w_done;
    logic [W+1:0]      w_m_ext;
    logic [W+1:0]      w_sum;
    logic [W+1:0]      w_a_nxt;
    logic [W:0]        w_q_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // busy/done decode only the state register, so inputs never reach outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_last      = (r_cnt == C_LAST);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One Booth step: add/subtract M by {Q0,E}, then arithmetic shift of {A,Q,E}
    always_comb begin
        w_m_ext = {r_m[W], r_m};
        case ({r_q[0], r_e})
            2'b10:   w_sum = r_a - w_m_ext;
            2'b01:   w_sum = r_a + w_m_ext;
            default: w_sum = r_a;
        endcase
        w_a_nxt = {w_sum[W+1], w_sum[W+1:1]};
        w_q_nxt = {w_sum[0], r_q[W:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_q       <= '0;
            r_e       <= 1'b0;
            r_a       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_m   <= {bus.is_signed & bus.a[W-1], bus.a};
            r_q   <= {bus.is_signed & bus.b[W-1], bus.b};
            r_e   <= 1'b0;
            r_a   <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_e   <= r_q[0];
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= {w_a_nxt[W-2:0], w_q_nxt};
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_mult
// Brief    : Scoreboard bench for booth_seq_mult at W=4, W=8 and W=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mult;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth_seq_mult_if #(.W(4))  if4 ();
    booth_seq_mult_if #(.W(8))  if8 ();
    booth_seq_mult_if #(.W(16)) if16 ();

    booth_seq_mult #(.W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    booth_seq_mult #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    booth_seq_mult #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    int n_checks = 0;
    int n_errors = 0;
    int n_done8  = 0;

    logic [31:0] sb4[$];
    logic [31:0] sb8[$];
    logic [31:0] sb16[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input int w, input bit s,
                                             input logic [15:0] a, input logic [15:0] b);
        longint m;
        longint va;
        longint vb;
        longint p;
        m  = (longint'(1) << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        p = (va * vb) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    // Scoreboard consumers: every done pulse pops one expected product
    always @(negedge clk) begin
        if (!rst && if4.done) begin
            if (sb4.size() == 0) check_val("done4_unexpected", 32'(if4.done), 32'd0);
            else                 check_val("prod4", 32'(if4.product), sb4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && if8.done) begin
            n_done8++;
            if (sb8.size() == 0) check_val("done8_unexpected", 32'(if8.done), 32'd0);
            else                 check_val("prod8", 32'(if8.product), sb8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && if16.done) begin
            if (sb16.size() == 0) check_val("done16_unexpected", 32'(if16.done), 32'd0);
            else                  check_val("prod16", if16.product, sb16.pop_front());
        end
    end

    task automatic issue(input int w, input bit s, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp);
        @(negedge clk);
        case (w)
            4: begin
                if4.start = 1'b1; if4.is_signed = s; if4.a = a[3:0]; if4.b = b[3:0];
                sb4.push_back(exp);
            end
            8: begin
                if8.start = 1'b1; if8.is_signed = s; if8.a = a[7:0]; if8.b = b[7:0];
                sb8.push_back(exp);
            end
            default: begin
                if16.start = 1'b1; if16.is_signed = s; if16.a = a; if16.b = b;
                sb16.push_back(exp);
            end
        endcase
        @(negedge clk);
        if4.start  = 1'b0;
        if8.start  = 1'b0;
        if16.start = 1'b0;
    endtask

    task automatic wait_done(input int w, input string tag);
        int t;
        bit d;
        t = 0;
        d = 1'b0;
        while (t < 40) begin
            case (w)
                4:       d = if4.done;
                8:       d = if8.done;
                default: d = if16.done;
            endcase
            if (d) break;
            @(negedge clk);
            t++;
        end
        check_val(tag, 32'(d), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int t;
        int rem;
        int n0;
        logic [31:0] r;
        bit s;

        rst = 1'b1;
        if4.start  = 1'b0; if4.is_signed  = 1'b0; if4.a  = '0; if4.b  = '0;
        if8.start  = 1'b0; if8.is_signed  = 1'b0; if8.a  = '0; if8.b  = '0;
        if16.start = 1'b0; if16.is_signed = 1'b0; if16.a = '0; if16.b = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy8", 32'(if8.busy), 32'd0);
        check_val("rst_done8", 32'(if8.done), 32'd0);
        check_val("rst_prod8", 32'(if8.product), 32'd0);
        check_val("rst_prod16", if16.product, 32'd0);
        rst = 1'b0;

        // -3 * 5 signed: busy for exactly W+1 cycles, one-cycle done
        issue(8, 1'b1, 16'h00FD, 16'h0005, 32'h0000_FFF1);
        nb = 0;
        t  = 0;
        while (!if8.done && t < 30) begin
            if (if8.busy) nb++;
            @(negedge clk);
            t++;
        end
        check_val("busy8_cycles", 32'(nb), 32'd9);
        check_val("done8_seen", 32'(if8.done), 32'd1);
        check_val("busy8_in_done", 32'(if8.busy), 32'd0);
        @(negedge clk);
        check_val("done8_width", 32'(if8.done), 32'd0);
        check_val("prod8_hold", 32'(if8.product), 32'h0000_FFF1);

        issue(8, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000);
        wait_done(8, "done8");
        issue(8, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080);
        wait_done(8, "done8");
        issue(8, 1'b0, 16'h0000, 16'h00C8, 32'h0000_0000);
        wait_done(8, "done8");
        issue(8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01);
        wait_done(8, "done8");

        // Reset mid-RUN discards the operation
        issue(8, 1'b1, 16'h0012, 16'h0034, ref_prod(8, 1'b1, 16'h0012, 16'h0034));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb8.delete();
        @(negedge clk);
        check_val("midrst_busy8", 32'(if8.busy), 32'd0);
        check_val("midrst_done8", 32'(if8.done), 32'd0);
        check_val("midrst_prod8", 32'(if8.product), 32'd0);
        rst = 1'b0;
        n0 = n_done8;
        repeat (15) @(negedge clk);
        check_val("midrst_no_done", 32'(n_done8 - n0), 32'd0);
        issue(8, 1'b0, 16'h000C, 16'h000B, 32'h0000_0084);
        wait_done(8, "done8_after_rst");

        // start held high with operands changing every cycle
        @(negedge clk);
        rem = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            r = $urandom;
            s = r[16];
            if8.start = 1'b1; if8.is_signed = s; if8.a = r[7:0]; if8.b = r[15:8];
            if (rem == 0) begin
                sb8.push_back(ref_prod(8, s, {8'd0, r[7:0]}, {8'd0, r[15:8]}));
                rem = 9;
            end else begin
                rem--;
            end
        end
        @(negedge clk);
        if8.start = 1'b0;
        t = 0;
        while (sb8.size() > 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check_val("b2b_drain", 32'(sb8.size()), 32'd0);

        // W=4 exhaustive, both modes
        for (int sm = 0; sm < 2; sm++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    issue(4, sm[0], 16'(ia), 16'(ib), ref_prod(4, sm[0], 16'(ia), 16'(ib)));
                    wait_done(4, "done4");
                end
            end
        end

        // W=16 random, both modes
        for (int sm = 0; sm < 2; sm++) begin
            for (int k = 0; k < 1000; k++) begin
                r = $urandom;
                issue(16, sm[0], r[15:0], r[31:16], ref_prod(16, sm[0], r[15:0], r[31:16]));
                wait_done(16, "done16");
            end
        end

        repeat (3) @(negedge clk);
        check_val("sb4_empty", 32'(sb4.size()), 32'd0);
        check_val("sb16_empty", 32'(sb16.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential, parametrised Booth (radix-2) multiplier, the multi-cycle successor to the team's 4-bit combinational Booth block. It takes two W-bit operands, signed or unsigned by a per-operation mode bit, and computes one Booth step per clock. A start/busy/done handshake lets it sit behind the TinyTapeout I/O wrapper or a small controller. It trades latency for area versus the unrolled combinational form and scales to any width ≥ 2.

## Interface
- W, default 8, operand width in bits (≥ 2); product is 2W bits
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is accepting (IDLE or DONE)
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a  in  W  multiplicand; captured with start
- b  in  W  multiplier; captured with start
- busy  out  1  high while iterating (RUN state)
- done  out  1  one-cycle pulse: product valid and newly updated
- product  out  2W  result register; holds last result until overwritten

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge: capture operands, clear accumulator, go to RUN with count=0.
- Operand extension to W+1 bits: is_signed=1 sign-extends, is_signed=0 zero-extends a and b. Multiplicand M (W+1 bits); multiplier Q (W+1 bits); Booth bit E=0; accumulator A of W+2 bits (one guard bit so M subtraction cannot overflow).
- RUN, one iteration per edge: pair {Q[0],E}: 10 -> A = A − M; 01 -> A = A + M; 00/11 -> A unchanged. Then arithmetic right shift of {A,Q,E} by one (A MSB replicated). count increments.
- After W+1 iterations: product <= low 2W bits of the 2(W+1)-bit {A,Q} result, go to DONE. Result is exact in both modes (range fits 2W bits).
- DONE: done=1, busy=0 for exactly one cycle. If start=1 at this edge, accept new operation straight into RUN (back-to-back); otherwise return to IDLE.
- start while RUN: ignored; captured operands unaffected.
- Operands a, b, is_signed may change freely after the accept edge.
- Arithmetic on A is modulo 2^(W+2); no saturation, no overflow flag.

## Timing
- Reset (rst=1 at an edge, any state, including mid-RUN): state=IDLE, busy=0, done=0, product=0, accumulator/count cleared; in-flight operation discarded, no done pulse. rst has priority over start.
- Accept edge k (start=1 in IDLE/DONE): busy=1 from k through k+W+1 edges (W+1 cycles high).
- Edge k+W+1: product updated, done=1, busy=0 for the following cycle.
- Latency start-accept to done: W+1 cycles; W=8 -> 9 cycles. Throughput with back-to-back start: one result per W+2 cycles.
- product changes only on the edge entering DONE or on reset; stable otherwise.
- No combinational path from inputs to outputs.

## Test plan
- W=8, is_signed=1, a=−3 (0xFD), b=5 -> after 9 cycles done pulse, product=0xFFF1 (−15); busy high exactly 9 cycles.
- W=8, is_signed=1, a=b=−128 (0x80) -> product=0x4000 (16384); also a=−128,b=127 -> 0xC080 (−16256).
- W=8, is_signed=0, a=b=255 -> product=0xFE01 (65025); a=0,b=200 -> 0x0000 with done still pulsed.
- W=8: start held high continuously with changing operands -> new op accepted only on DONE edges; each result matches operands present at its accept edge; start pulses during RUN have no effect.
- W=8: rst asserted 4 cycles into RUN -> next cycle busy=0, done=0, product=0; no done pulse follows; a fresh start then completes normally.
- W=4 exhaustive sweep, both modes, all 256 operand pairs -> every product equals the reference integer product mod 2^8; W=16 random 1000 vectors per mode likewise.
